tmds_decoder: RTL and testbench
===============================

# tmds_decoder

TMDS 8b/10b decoder with automatic symbol alignment, the receive-side counterpart of the TMDS encoder channel. It takes one unaligned 10-bit parallel word per clock from a per-channel deserializer. It locates the 10-bit symbol boundary by hunting for control tokens, then decodes data symbols to 8-bit pixel data and control symbols to c0/c1/de. One instance per TMDS channel sits between the deserializer and the video timing recovery logic.

## Interface
- `LOCK_COUNT`, 8: consecutive control tokens at one offset required to lock.
- `SEARCH_CYCLES`, 2048: cycles spent testing one offset before advancing.
- `LOSS_CYCLES`, 65536: cycles without a control token at the locked offset before lock is dropped.
- `clk` in 1: pixel (word) clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `din` in 10: raw deserialized word; bit 0 is the earliest received bit.
- `dout` out 8: decoded pixel data.
- `c0` out 1: decoded control bit 0 (hsync on channel 0).
- `c1` out 1: decoded control bit 1 (vsync on channel 0).
- `de` out 1: 1 = `dout` carries a data symbol.
- `locked` out 1: symbol alignment established.

## Operation
- Alignment window:
  - `prev` is `din` registered.
  - `w = {din, prev}` is 20 bits.
  - The candidate symbol at offset k (0..9) is `w[k+9:k]`.
  - The candidate is registered as `sym` (stage 2).
- Control tokens, with {c1,c0}:
  - 10'h354 → 00
  - 10'h0AB → 01
  - 10'h154 → 10
  - 10'h2AB → 11
- Data decode:
  - `d = sym[9] ? ~sym[7:0] : sym[7:0]`
  - `dout[0] = d[0]`
  - For i=1..7: `dout[i] = sym[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])`. Here sym[8]=1 means XOR-coded.
- State machine has two states, SEARCH and LOCKED. Token detection is evaluated on the candidate at the current offset.
- SEARCH:
  - `hit_cnt` increments on each token and clears on each non-token.
  - `search_tmr` increments every cycle.
  - If `hit_cnt` reaches LOCK_COUNT → LOCKED; the offset is held and `loss_tmr` is cleared.
  - Else if `search_tmr` reaches SEARCH_CYCLES-1:
    - offset advances (9 wraps to 0);
    - `hit_cnt` and `search_tmr` clear.
  - Simultaneous lock and timer expiry: lock wins and the offset is not advanced.
- LOCKED:
  - Any token at the offset clears `loss_tmr`; otherwise it increments.
  - If `loss_tmr` reaches LOSS_CYCLES-1 → SEARCH:
    - offset advances by one;
    - all counters clear.
- Output stage (stage 3), registered:
  - If state is LOCKED, a token drives de=0, c1/c0 from the token and dout=0.
  - If state is LOCKED, data drives de=1, c0/c1 hold their last values, and dout is decoded.
  - If state is SEARCH: dout=0, c0=0, c1=0, de=0.
- Counter widths are $clog2 of the respective parameter. Counters saturate and never wrap.
- Every 10-bit non-token word is decoded as data; no symbol is rejected.

## Timing
- Reset values:
  - `dout`=0, `c0`=0, `c1`=0, `de`=0, `locked`=0.
  - State SEARCH, offset 0, all counters 0.
- Reset asserts asynchronously and releases on the next `clk` edge.
- Latency: there are 3 register stages (`prev`, `sym`, output).
  - With offset 0, a word presented before edge E appears on the outputs after edge E+2.
  - With offset k>0, the symbol spans two input words; latency is counted from the later word.
- `locked` is registered and rises on the same edge the state enters LOCKED.
- The first decoded output follows one edge later.
- Reset mid-operation: all outputs clear immediately and the search restarts at offset 0.

## Configuration
- `TMDS_DECODER_DBG_EN` defined:
  - adds output `align_offset` (4 bits, current offset, reset 0);
  - adds output `lock_loss_cnt` (8 bits, saturating count of LOCKED→SEARCH transitions, reset 0).
- Not defined: both ports and their logic are absent.
- Alignment and decode behaviour is identical in both builds.

## Structure
- Package `tmds_pkg`:
  - the four control-token constants;
  - the state enum (SEARCH, LOCKED);
  - a `tmds_ctrl_t` {c1,c0} typedef.
  - The encoder side shares the package.
- Sub-module `tmds_symbol_decode`, purely combinational:
  - input: 10-bit symbol;
  - outputs: is_token, {c1,c0}, 8-bit data.
  - It is instantiated once on `sym`; the token check on the candidate uses the package constants.

## Test plan
Use SEARCH_CYCLES=64 and LOSS_CYCLES=256.
- Reset: hold `rst_n`=0 with random `din` → all outputs 0, `locked`=0; with DBG, `align_offset`=0.
- Aligned stream: 16× 10'h354, then 10'h100, then 10'h200 → `locked`=1 after the 8th token. Then de=0,{c1,c0}=00 for the tokens, dout=8'h00 de=1, dout=8'hFF de=1, each with 3-edge latency.
- Control decode (locked): 10'h0AB, 10'h154, 10'h2AB → {c1,c0} = 01, 10, 11 with de=0.
- Misaligned stream: serial stream shifted by 3 bits, repeating 10'h354 blanks of 32 words between 64-word data bursts → locks with offset 3 within 4×64 + 96 cycles, then decodes the data bytes correctly.
- Loss: lock, then send 300 data words of 10'h100 → `locked` falls after 256 cycles, outputs 0, offset advances to 1. With DBG, `lock_loss_cnt`=1.
- Async reset mid-lock: pull `rst_n` low between edges → `locked`, `de` and `dout` clear before the next edge. After release, relock needs 8 fresh tokens.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four control tokens, the receiver alignment states
// and the {c1,c0} control pair. The encoder side uses the same package.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } tmds_state_e;

  typedef struct packed {
    logic c1;
    logic c0;
  } tmds_ctrl_t;

  function automatic logic is_ctrl_token(input logic [9:0] s);
    return (s == CTRL_TOKEN_00) || (s == CTRL_TOKEN_01) ||
           (s == CTRL_TOKEN_10) || (s == CTRL_TOKEN_11);
  endfunction

  // Non-token symbols map to 00; callers qualify with is_ctrl_token.
  function automatic tmds_ctrl_t token_ctrl(input logic [9:0] s);
    tmds_ctrl_t c;
    case (s)
      CTRL_TOKEN_01: c = '{c1: 1'b0, c0: 1'b1};
      CTRL_TOKEN_10: c = '{c1: 1'b1, c0: 1'b0};
      CTRL_TOKEN_11: c = '{c1: 1'b1, c0: 1'b1};
      default:       c = '{c1: 1'b0, c0: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tmds_decoder_symbol_decode.sv
// Combinational TMDS symbol decoder: classifies a 10-bit symbol as control token
// or data and recovers the 8-bit pixel value for data symbols.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic       is_token,
  output tmds_ctrl_t ctrl,
  output logic [7:0] data
);

  logic [7:0] d;

  always_comb begin
    is_token = is_ctrl_token(sym);
    ctrl     = token_ctrl(sym);
    // sym[9] marks an inverted payload; sym[8]=1 selects XOR chaining, 0 XNOR.
    d        = sym[9] ? ~sym[7:0] : sym[7:0];
    data     = '0;
    data[0]  = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive channel: hunts for the symbol boundary using control tokens, then
// decodes aligned symbols. Define TMDS_DECODER_DBG_EN to expose align_offset/lock_loss_cnt.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT    = 8,
  parameter int SEARCH_CYCLES = 2048,
  parameter int LOSS_CYCLES   = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       de,
  output logic       locked
`ifdef TMDS_DECODER_DBG_EN
  ,
  output logic [3:0] align_offset,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam int HIT_W  = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int STMR_W = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
  localparam int LTMR_W = (LOSS_CYCLES > 1) ? $clog2(LOSS_CYCLES) : 1;

  localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(LOCK_COUNT - 1);
  localparam logic [STMR_W-1:0] STMR_LAST = STMR_W'(SEARCH_CYCLES - 1);
  localparam logic [LTMR_W-1:0] LTMR_LAST = LTMR_W'(LOSS_CYCLES - 1);

  logic [9:0]        prev_q;
  logic [9:0]        sym_q, sym_d;
  tmds_state_e       state_q, state_d;
  logic [3:0]        offset_q, offset_d;
  logic [HIT_W-1:0]  hit_q, hit_d;
  logic [STMR_W-1:0] stmr_q, stmr_d;
  logic [LTMR_W-1:0] ltmr_q, ltmr_d;
  logic [7:0]        dout_q, dout_d;
  tmds_ctrl_t        ctrl_q, ctrl_d;
  logic              de_q, de_d;

  // din[9] can never fall inside a candidate window; it only reaches prev_q.
  logic [18:0] win;
  logic [9:0]  cand_arr [10];
  logic        cand_tok;
  logic [3:0]  offset_inc;

  assign win = {din[8:0], prev_q};

  for (genvar gi = 0; gi < 10; gi++) begin : g_cand
    assign cand_arr[gi] = win[gi+9:gi];
  end

  assign sym_d      = cand_arr[offset_q];
  assign cand_tok   = is_ctrl_token(sym_d);
  assign offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    hit_d    = hit_q;
    stmr_d   = stmr_q;
    ltmr_d   = ltmr_q;
    case (state_q)
      SEARCH: begin
        hit_d  = cand_tok ? hit_q + 1'b1 : '0;
        stmr_d = (stmr_q == STMR_LAST) ? stmr_q : stmr_q + 1'b1;
        // Lock takes priority over the offset timer expiring on the same cycle.
        if (cand_tok && hit_q == HIT_LAST) begin
          state_d = LOCKED;
          hit_d   = '0;
          stmr_d  = '0;
          ltmr_d  = '0;
        end else if (stmr_q == STMR_LAST) begin
          offset_d = offset_inc;
          hit_d    = '0;
          stmr_d   = '0;
        end
      end
      LOCKED: begin
        if (cand_tok) begin
          ltmr_d = '0;
        end else if (ltmr_q == LTMR_LAST) begin
          state_d  = SEARCH;
          offset_d = offset_inc;
          hit_d    = '0;
          stmr_d   = '0;
          ltmr_d   = '0;
        end else begin
          ltmr_d = ltmr_q + 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  logic       sym_is_token;
  tmds_ctrl_t sym_ctrl;
  logic [7:0] sym_data;

  tmds_symbol_decode u_symbol_decode (
    .sym      (sym_q),
    .is_token (sym_is_token),
    .ctrl     (sym_ctrl),
    .data     (sym_data)
  );

  always_comb begin
    dout_d = '0;
    ctrl_d = '0;
    de_d   = 1'b0;
    if (state_q == LOCKED) begin
      if (sym_is_token) begin
        ctrl_d = sym_ctrl;
      end else begin
        de_d   = 1'b1;
        dout_d = sym_data;
        ctrl_d = ctrl_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      sym_q    <= '0;
      state_q  <= SEARCH;
      offset_q <= '0;
      hit_q    <= '0;
      stmr_q   <= '0;
      ltmr_q   <= '0;
      dout_q   <= '0;
      ctrl_q   <= '0;
      de_q     <= 1'b0;
    end else begin
      prev_q   <= din;
      sym_q    <= sym_d;
      state_q  <= state_d;
      offset_q <= offset_d;
      hit_q    <= hit_d;
      stmr_q   <= stmr_d;
      ltmr_q   <= ltmr_d;
      dout_q   <= dout_d;
      ctrl_q   <= ctrl_d;
      de_q     <= de_d;
    end
  end

  assign dout   = dout_q;
  assign c0     = ctrl_q.c0;
  assign c1     = ctrl_q.c1;
  assign de     = de_q;
  assign locked = (state_q == LOCKED);

`ifdef TMDS_DECODER_DBG_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (state_q == LOCKED && state_d == SEARCH && loss_cnt_q != 8'hFF) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign align_offset  = offset_q;
  assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: reset, aligned lock and decode, control tokens,
// lock loss, misaligned (offset 3) stream lock and decode, asynchronous reset mid-lock.
module tb_tmds_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = '0;
  logic [7:0] dout;
  logic       c0, c1, de, locked;
`ifdef TMDS_DECODER_DBG_EN
  logic [3:0] align_offset;
  logic [7:0] lock_loss_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  tmds_decoder #(
    .LOCK_COUNT    (8),
    .SEARCH_CYCLES (64),
    .LOSS_CYCLES   (256)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .dout   (dout),
    .c0     (c0),
    .c1     (c1),
    .de     (de),
    .locked (locked)
`ifdef TMDS_DECODER_DBG_EN
    ,
    .align_offset  (align_offset),
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Aligned stream and its expected outputs packed as {de, c1, c0, dout}.
  logic [9:0]  aw [25] = '{10'h354, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354,
                           10'h354, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354,
                           10'h354, 10'h354, 10'h354, 10'h354, 10'h100, 10'h200,
                           10'h0AB, 10'h154, 10'h2AB, 10'h100, 10'h354, 10'h354,
                           10'h354};
  logic [10:0] ae [25] = '{11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000,
                           11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000,
                           11'h000, 11'h000, 11'h000, 11'h000, 11'h400, 11'h4FF,
                           11'h100, 11'h200, 11'h300, 11'h700, 11'h000, 11'h000,
                           11'h000};

  // Data symbols of the misaligned bursts and their hand-decoded bytes.
  logic [9:0]  dsym  [5] = '{10'h100, 10'h200, 10'h155, 10'h2AA, 10'h133};
  logic [7:0]  dbyte [5] = '{8'h00,   8'hFF,   8'hFF,   8'h01,   8'h55};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outv();
    return {21'b0, de, c1, c0, dout};
  endfunction

  task automatic step(input logic [9:0] w);
    din = w;
    @(posedge clk);
    #1;
  endtask

  // Misaligned stream: 96-symbol period, 32 blanks then a 64-symbol data burst.
  function automatic logic [9:0] msym(input int m);
    int p;
    if (m < 0) return 10'h280;
    p = m % 96;
    if (p < 32) return 10'h354;
    return dsym[(p - 32) % 5];
  endfunction

  // Three junk bits lead the serial stream, so symbol m starts at bit 3 of word m.
  function automatic logic [9:0] mword(input int n);
    logic [9:0] cur, prv;
    cur = msym(n);
    prv = msym(n - 1);
    return {cur[6:0], prv[9:7]};
  endfunction

  function automatic logic [31:0] mexp(input int m);
    int p;
    p = m % 96;
    if (p < 32) return 32'h000;
    return {21'b0, 3'b100, dbyte[(p - 32) % 5]};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got_lock;
    int lock_n;

    // Reset held with random input.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = 10'($urandom);
      @(posedge clk);
      #1;
      chk("reset_out", outv(), 32'h0);
      chk("reset_locked", {31'b0, locked}, 32'h0);
`ifdef TMDS_DECODER_DBG_EN
      chk("reset_offset", {28'b0, align_offset}, 32'h0);
`endif
    end
    rst_n = 1'b1;

    // Aligned tokens, data and control decode.
    for (int j = 0; j < 25; j++) begin
      step(aw[j]);
      if (j == 7) chk("pre_lock", {31'b0, locked}, 32'h0);
      if (j == 8) begin
        chk("lock_edge", {31'b0, locked}, 32'h1);
        chk("search_out", outv(), 32'h0);
      end
      if (j >= 9) chk("aligned_out", outv(), {21'b0, ae[j-2]});
    end

    // Loss of lock after 256 non-token cycles.
    for (int i = 0; i < 300; i++) begin
      step(10'h100);
      if (i == 255) begin
        chk("loss_still_locked", {31'b0, locked}, 32'h1);
        chk("loss_data_out", outv(), 32'h400);
      end
      if (i == 256) chk("loss_unlocked", {31'b0, locked}, 32'h0);
      if (i == 257) chk("loss_out_zero", outv(), 32'h0);
    end
`ifdef TMDS_DECODER_DBG_EN
    chk("loss_offset", {28'b0, align_offset}, 32'h1);
    chk("loss_count", {24'b0, lock_loss_cnt}, 32'h1);
`endif

    // Misaligned stream at offset 3.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    got_lock = 1'b0;
    lock_n   = 0;
    for (int n = 0; n < 420; n++) begin
      step(mword(n));
      if (got_lock) chk("mis_out", outv(), mexp(n - 2));
      if (!got_lock && locked) begin
        got_lock = 1'b1;
        lock_n   = n;
      end
    end
    chk("mis_lock_in_time", {31'b0, (got_lock && lock_n < 352)}, 32'h1);
    chk("mis_still_locked", {31'b0, locked}, 32'h1);
`ifdef TMDS_DECODER_DBG_EN
    chk("mis_offset", {28'b0, align_offset}, 32'h3);
`endif

    // Asynchronous reset between edges while locked and carrying data.
    step(mword(420));
    step(mword(421));
    step(mword(422));
    chk("pre_areset_de", {31'b0, de}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_locked", {31'b0, locked}, 32'h0);
    chk("areset_out", outv(), 32'h0);
    #2 rst_n = 1'b1;
    for (int j = 0; j < 11; j++) begin
      step(10'h354);
      if (j == 7) chk("relock_pending", {31'b0, locked}, 32'h0);
      if (j == 8) chk("relock", {31'b0, locked}, 32'h1);
      if (j == 10) chk("relock_out", outv(), 32'h000);
    end
`ifdef TMDS_DECODER_DBG_EN
    chk("relock_offset", {28'b0, align_offset}, 32'h0);
    chk("relock_count", {24'b0, lock_loss_cnt}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
